// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both transmit and receive sides.
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 32;
    localparam int I2S_SCK_DIV    = 8;
    localparam int FRAME_BITS     = 2 * I2S_DATA_WIDTH;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } slot_ptr_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock and word-select generator; also flags sck falls and the slot-1 load point.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int SCK_DIV    = I2S_SCK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic sck,
    output logic ws,
    output logic fall_evt,
    output logic load_evt
);

    localparam int CNT_W = $clog2(SCK_DIV);
    localparam int BIT_W = $clog2(2 * DATA_WIDTH);

    logic [CNT_W-1:0] sck_cnt, sck_cnt_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;

    always_comb begin
        fall_evt    = (sck_cnt == CNT_W'(SCK_DIV - 1));
        sck_cnt_nxt = fall_evt ? '0 : sck_cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        if (fall_evt) begin
            bit_cnt_nxt = (bit_cnt == BIT_W'(2 * DATA_WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
        end
        load_evt = fall_evt && (bit_cnt == '0);
    end

    // sck and ws are registered from the next-state counts so they move together with sd
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
        end else begin
            sck_cnt <= sck_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            sck     <= (sck_cnt_nxt >= CNT_W'(SCK_DIV / 2));
            ws      <= (bit_cnt_nxt >= BIT_W'(DATA_WIDTH));
        end
    end

endmodule

// File: rtl/i2s_transmit.sv
// I2S master transmitter: AXI4-Stream stereo words in, sck/ws/sd out, one frame buffered.
module i2s_transmit
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int SCK_DIV    = I2S_SCK_DIV
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESETN,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    output logic                  sck,
    output logic                  ws,
    output logic                  sd,
    output logic                  underrun,
    output logic                  frame_err
);

    localparam int FW = 2 * DATA_WIDTH;

    logic                  fall_evt, load_evt;
    logic [DATA_WIDTH-1:0] buf_l, buf_r;
    logic [FW-1:0]         sh, sh_nxt;
    slot_ptr_t             ptr, ptr_nxt;
    logic                  full, full_nxt;
    logic                  accept, write_l, write_r;
    logic                  underrun_nxt, frame_err_nxt;

    i2s_clk_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .SCK_DIV    (SCK_DIV)
    ) u_clk_gen (
        .clk      (S_AXIS_ACLK),
        .rst_n    (S_AXIS_ARESETN),
        .sck      (sck),
        .ws       (ws),
        .fall_evt (fall_evt),
        .load_evt (load_evt)
    );

    assign S_AXIS_TREADY = S_AXIS_ARESETN && !full;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign sd            = sh[FW-1];

    always_comb begin
        ptr_nxt       = ptr;
        full_nxt      = full;
        write_l       = 1'b0;
        write_r       = 1'b0;
        frame_err_nxt = 1'b0;
        sh_nxt        = sh;
        underrun_nxt  = 1'b0;

        // The load looks at the pre-edge full; a frame completing this cycle waits one frame
        if (fall_evt) begin
            if (load_evt) begin
                sh_nxt       = full ? {buf_l, buf_r} : '0;
                underrun_nxt = !full;
                full_nxt     = 1'b0;
            end else begin
                sh_nxt = {sh[FW-2:0], 1'b0};
            end
        end

        if (accept) begin
            unique case (ptr)
                LEFT: begin
                    if (S_AXIS_TLAST) begin
                        frame_err_nxt = 1'b1;
                    end else begin
                        write_l = 1'b1;
                        ptr_nxt = RIGHT;
                    end
                end
                RIGHT: begin
                    write_r       = 1'b1;
                    full_nxt      = 1'b1;
                    ptr_nxt       = LEFT;
                    frame_err_nxt = !S_AXIS_TLAST;
                end
                default: ptr_nxt = LEFT;
            endcase
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            ptr       <= LEFT;
            full      <= 1'b0;
            sh        <= '0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            full      <= full_nxt;
            sh        <= sh_nxt;
            underrun  <= underrun_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Holding words are qualified by full, so they need no reset
    always_ff @(posedge S_AXIS_ACLK) begin
        if (write_l) buf_l <= S_AXIS_TDATA;
        if (write_r) buf_r <= S_AXIS_TDATA;
    end

endmodule

// File: tb/tb_i2s_transmit.sv
// Directed bench for i2s_transmit: decodes sd as an I2S receiver would and checks frames and flags.
module tb_i2s_transmit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic        sck, ws, sd, underrun, frame_err;

    always #5 clk = ~clk;

    i2s_transmit #(
        .DATA_WIDTH (32),
        .SCK_DIV    (8)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rstn),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TREADY  (tready),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TLAST   (tlast),
        .sck            (sck),
        .ws             (ws),
        .sd             (sd),
        .underrun       (underrun),
        .frame_err      (frame_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    // Line monitor: sd is sampled on sck rises; a word boundary is ws falling at slot 0
    int          cyc = 0;
    int          last_rise = 0, sck_per = 0;
    int          last_ws = 0, ws_int = 0;
    int          last_ur = 0, ur_int = 0, ur_cnt = 0;
    int          fe_cnt = 0, sd_ones = 0;
    logic        sck_q = 1'b0, ws_q = 1'b0, ws_rise_q = 1'b0;
    logic [63:0] hist = '0;
    logic [63:0] frames[$];

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            sck_q     = 1'b0;
            ws_q      = 1'b0;
            ws_rise_q = 1'b0;
        end else begin
            if (sck && !sck_q) begin
                sck_per   = cyc - last_rise;
                last_rise = cyc;
                hist      = {hist[62:0], sd};
                if (!ws && ws_rise_q) frames.push_back(hist);
                ws_rise_q = ws;
            end
            if (ws !== ws_q) begin
                ws_int  = cyc - last_ws;
                last_ws = cyc;
            end
            if (underrun) begin
                ur_int  = cyc - last_ur;
                last_ur = cyc;
                ur_cnt++;
            end
            if (frame_err) fe_cnt++;
            if (sd) sd_ones++;
            sck_q = sck;
            ws_q  = ws;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [31:0] d, input logic last);
        int   n;
        logic ok;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        n      = 0;
        ok     = 1'b0;
        while (n < 3000 && !ok) begin
            if (tready) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        check("send_accepted", 64'(ok), 64'(1));
    endtask

    function automatic int first_nonzero();
        int idx = -1;
        for (int i = 0; i < frames.size(); i++) begin
            if (idx < 0 && frames[i] != 64'h0) idx = i;
        end
        return idx;
    endfunction

    function automatic logic [63:0] frame_at(input int idx);
        if (idx >= 0 && idx < frames.size()) return frames[idx];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        int fe0;
        rstn   = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_sck",       64'(sck),       64'(0));
        check("rst_ws",        64'(ws),        64'(0));
        check("rst_sd",        64'(sd),        64'(0));
        check("rst_tready",    64'(tready),    64'(0));
        check("rst_underrun",  64'(underrun),  64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));

        // Idle after release: zeros, periodic underrun
        rstn = 1'b1;
        @(negedge clk);
        check("tready_after_release", 64'(tready), 64'(1));
        sd_ones = 0;
        ur_cnt  = 0;
        frames.delete();
        repeat (1100) @(negedge clk);
        check("idle_sck_period",  64'(sck_per), 64'(8));
        check("idle_ws_interval", 64'(ws_int),  64'(256));
        check("idle_ur_interval", 64'(ur_int),  64'(512));
        check("idle_ur_count",    64'(ur_cnt),  64'(3));
        check("idle_sd_zero",     64'(sd_ones), 64'(0));
        check("idle_frame_count", 64'(frames.size()), 64'(2));
        check("idle_frame_zero",  frame_at(0),  64'h0);

        // One frame, wire order and channel placement
        frames.delete();
        send(32'hA5A5_0001, 1'b0);
        check("half_frame_tready", 64'(tready), 64'(1));
        send(32'h8000_00FF, 1'b1);
        check("full_tready", 64'(tready), 64'(0));
        repeat (1300) @(negedge clk);
        check("single_frame", frame_at(first_nonzero()), 64'hA5A5_0001_8000_00FF);

        // Ramp: back-to-back frames without underrun gaps
        frames.delete();
        for (int i = 0; i < 8; i++) begin
            send(32'(i), i[0]);
            if (i[0]) check("ramp_tready_low", 64'(tready), 64'(0));
        end
        repeat (1200) @(negedge clk);
        idx = first_nonzero();
        for (int k = 0; k < 4; k++) begin
            check("ramp_frame", frame_at(idx + k), {32'(2 * k), 32'(2 * k + 1)});
        end

        // Framing violations
        fe0 = fe_cnt;
        frames.delete();
        send(32'h1111_1111, 1'b1);
        repeat (2) @(negedge clk);
        check("fe_left_tlast", 64'(fe_cnt - fe0), 64'(1));
        send(32'h2222_2222, 1'b0);
        send(32'h3333_3333, 1'b1);
        repeat (2) @(negedge clk);
        check("fe_good_frame", 64'(fe_cnt - fe0), 64'(1));
        send(32'h4444_4444, 1'b0);
        send(32'h5555_5555, 1'b0);
        repeat (2) @(negedge clk);
        check("fe_right_no_tlast", 64'(fe_cnt - fe0), 64'(2));
        repeat (1200) @(negedge clk);
        idx = first_nonzero();
        check("fe_frame_a", frame_at(idx),     64'h2222_2222_3333_3333);
        check("fe_frame_b", frame_at(idx + 1), 64'h4444_4444_5555_5555);

        // Frame completes on the very cycle of the slot-1 load
        n = 0;
        while (!underrun && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("collide_sync_ur", 64'(underrun), 64'(1));
        send(32'hCAFE_0001, 1'b0);
        repeat (510) @(negedge clk);
        send(32'hBEEF_0002, 1'b1);
        check("collide_underrun", 64'(underrun), 64'(1));
        check("collide_tready",   64'(tready),   64'(0));
        frames.delete();
        repeat (1100) @(negedge clk);
        check("collide_zero_frame", frame_at(0), 64'h0);
        check("collide_next_frame", frame_at(1), 64'hCAFE_0001_BEEF_0002);

        // Reset in slot 20 with a frame playing and another buffered
        send(32'h1234_5678, 1'b0);
        send(32'h9ABC_DEF0, 1'b1);
        n = 0;
        while (!tready && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("mid_load_seen", 64'(tready), 64'(1));
        send(32'h0F0F_0F0F, 1'b0);
        send(32'hF0F0_F0F0, 1'b1);
        repeat (155) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_sck",       64'(sck),       64'(0));
        check("mid_rst_ws",        64'(ws),        64'(0));
        check("mid_rst_sd",        64'(sd),        64'(0));
        check("mid_rst_tready",    64'(tready),    64'(0));
        check("mid_rst_underrun",  64'(underrun),  64'(0));
        check("mid_rst_frame_err", 64'(frame_err), 64'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        frames.delete();
        @(negedge clk);
        check("mid_rel_tready", 64'(tready), 64'(1));
        n = 1;
        while (!underrun && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_first_load_ur", 64'(n), 64'(8));
        repeat (600) @(negedge clk);
        check("mid_first_frame_zero", frame_at(0), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
